// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one split-handshake memory port between
// the fetch (i_*) and load/store (d_*) ports, one transaction at a time.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   i_valid/i_addr    fetch request; i_flush redirects the fetch stream
//   i_addr_ok         fetch request accepted
//   i_data_ok/i_rdata fetch response
//   d_valid..d_wdata  load/store request
//   d_addr_ok         data request accepted
//   d_data_ok/d_rdata load data or store completion
//   m_*               memory request out, m_addr_ok/m_data_ok/m_rdata in
//
// Data beats fetch. With ARB_FAIRNESS_EN defined, a starvation counter
// hands the grant to fetch after STARVE_LIMIT data wins in a row.

module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_valid,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,

  input  logic        d_valid,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,

  output logic        m_valid,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_strobe,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    I_ADDR,
    I_DATA,
    D_ADDR,
    D_DATA
  } state_e;

  state_e state_q, state_d;
  logic   kill_q, kill_d;

  logic starved;
  logic win_d, win_i;
  logic sel_d, sel_i;
  logic i_resp;

  // Arbitration result, only meaningful in IDLE.
  always_comb begin
    win_d = d_valid & ~(starved & i_valid);
    win_i = i_valid & ~win_d;
  end

  // Port currently driving the memory request (fresh win or locked).
  always_comb begin
    sel_d = ((state_q == IDLE) & win_d) | (state_q == D_ADDR);
    sel_i = ((state_q == IDLE) & win_i) | (state_q == I_ADDR);
  end

  always_comb begin
    m_valid  = 1'b0;
    m_write  = 1'b0;
    m_size   = 2'd0;
    m_addr   = 32'd0;
    m_strobe = 4'd0;
    m_wdata  = 32'd0;
    unique case (1'b1)
      sel_d: begin
        m_valid  = 1'b1;
        m_write  = d_write;
        m_size   = d_size;
        m_addr   = d_addr;
        m_strobe = d_strobe;
        m_wdata  = d_wdata;
      end
      sel_i: begin
        m_valid  = 1'b1;
        m_size   = 2'd2;
        m_addr   = i_addr;
      end
      default: ;
    endcase
  end

  assign i_addr_ok = sel_i & m_addr_ok;
  assign d_addr_ok = sel_d & m_addr_ok;

  assign i_resp    = (state_q == I_DATA) & m_data_ok;
  // A flush landing on the response cycle also makes that word stale.
  assign i_data_ok = i_resp & ~kill_q & ~i_flush;
  assign d_data_ok = (state_q == D_DATA) & m_data_ok;

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_d) begin
          state_d = m_addr_ok ? D_DATA : D_ADDR;
        end else if (win_i) begin
          state_d = m_addr_ok ? I_DATA : I_ADDR;
        end
      end
      I_ADDR: if (m_addr_ok) state_d = I_DATA;
      I_DATA: if (m_data_ok) state_d = IDLE;
      D_ADDR: if (m_addr_ok) state_d = D_DATA;
      D_DATA: if (m_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Kill marks the outstanding fetch as stale until its response drains.
  always_comb begin
    kill_d = kill_q;
    if (i_resp) begin
      kill_d = 1'b0;
    end else if (i_flush &
                 ((state_q == I_DATA) | i_addr_ok)) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign starved = (starve_q == LIMIT);

  // Counts data wins that left a waiting fetch behind.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (win_d & i_valid & (starve_q != LIMIT)) begin
        starve_d = starve_q + 4'd1;
      end else if (win_i) begin
        starve_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_limit;

  assign unused_limit = ^STARVE_LIMIT;
  assign starved      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed stimulus, transaction-level reference
// model compared every cycle, plus literal expectations per scenario.

module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;
`ifdef ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_flush;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_valid, d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_strobe;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        m_valid, m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_strobe;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  byte grants[$];

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_flush(i_flush),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .i_rdata(i_rdata),
    .d_valid(d_valid), .d_write(d_write), .d_size(d_size),
    .d_addr(d_addr), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .d_rdata(d_rdata),
    .m_valid(m_valid), .m_write(m_write), .m_size(m_size),
    .m_addr(m_addr), .m_strobe(m_strobe), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk1(string n, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endfunction

  function automatic void chk32(string n, logic [31:0] a,
                                logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic void chkw(string n, logic [71:0] a,
                               logic [71:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  // Reference model: one transaction record (owner, accepted, stale).
  bit  md_busy, md_acc, md_kill;
  byte md_owner;
  int  md_starve;

  function automatic byte winner();
    if (d_valid && !(FAIR && md_starve == LIMIT && i_valid))
      return "D";
    if (i_valid) return "I";
    return "N";
  endfunction

  function automatic byte requester();
    if (!md_busy) return winner();
    if (!md_acc) return md_owner;
    return "N";
  endfunction

  always @(posedge clk) begin
    byte r;
    r = requester();
    if (reset) begin
      md_busy   <= 1'b0;
      md_acc    <= 1'b0;
      md_kill   <= 1'b0;
      md_owner  <= "N";
      md_starve <= 0;
    end else if (!md_busy) begin
      if (r != "N") begin
        md_busy  <= 1'b1;
        md_owner <= r;
        md_acc   <= m_addr_ok;
        if (r == "I" && m_addr_ok && i_flush) md_kill <= 1'b1;
        if (r == "I") md_starve <= 0;
        else if (i_valid && md_starve < LIMIT)
          md_starve <= md_starve + 1;
      end
    end else if (!md_acc) begin
      if (m_addr_ok) begin
        md_acc <= 1'b1;
        if (md_owner == "I" && i_flush) md_kill <= 1'b1;
      end
    end else begin
      if (m_data_ok) begin
        md_busy <= 1'b0;
        if (md_owner == "I") md_kill <= 1'b0;
      end else if (md_owner == "I" && i_flush) begin
        md_kill <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    byte r;
    logic [71:0] e_req;
    logic i_ok, d_ok;
    if (reset !== 1'b1) begin
      r = requester();
      e_req = '0;
      if (r == "D")
        e_req = {1'b1, d_write, d_size, d_addr, d_strobe, d_wdata};
      else if (r == "I")
        e_req = {1'b1, 1'b0, 2'd2, i_addr, 4'd0, 32'd0};
      i_ok = md_busy && md_acc && md_owner == "I" && m_data_ok
             && !md_kill && !i_flush;
      d_ok = md_busy && md_acc && md_owner == "D" && m_data_ok;
      chkw("m_req",
           {m_valid, m_write, m_size, m_addr, m_strobe, m_wdata},
           e_req);
      chk1("i_addr_ok", i_addr_ok, (r == "I") && m_addr_ok);
      chk1("d_addr_ok", d_addr_ok, (r == "D") && m_addr_ok);
      chk1("i_data_ok", i_data_ok, i_ok);
      chk1("d_data_ok", d_data_ok, d_ok);
      chk32("i_rdata", i_rdata, m_rdata);
      chk32("d_rdata", d_rdata, m_rdata);
    end
  end

  task automatic idle_in();
    i_valid = 0; i_addr = 0; i_flush = 0;
    d_valid = 0; d_write = 0; d_size = 0;
    d_addr = 0; d_strobe = 0; d_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    idle_in();
    reset = 1;
    next(); next();
    reset = 0;
    mid();
    chk1("rst_m_valid", m_valid, 1'b0);
    chk32("rst_m_addr", m_addr, 32'h0);
    chk1("rst_i_addr_ok", i_addr_ok, 1'b0);
    chk1("rst_d_data_ok", d_data_ok, 1'b0);
    next();

    // Fetch only, zero-wait memory.
    i_valid = 1; i_addr = 32'hbfc00000; m_addr_ok = 1;
    mid();
    chk1("t1_i_addr_ok", i_addr_ok, 1'b1);
    chk32("t1_m_addr", m_addr, 32'hbfc00000);
    chk1("t1_m_write", m_write, 1'b0);
    chk32("t1_m_size", 32'(m_size), 32'd2);
    next();
    i_valid = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h3c1d0001;
    mid();
    chk1("t1_i_data_ok", i_data_ok, 1'b1);
    chk32("t1_i_rdata", i_rdata, 32'h3c1d0001);
    next();
    idle_in();
    mid();
    chk1("t1_idle_m_valid", m_valid, 1'b0);
    next();

    // Both request together: store first, fetch after.
    i_valid = 1; i_addr = 32'hbfc00004;
    d_valid = 1; d_write = 1; d_size = 2;
    d_addr = 32'h80001000; d_strobe = 4'hf;
    d_wdata = 32'hcafef00d; m_addr_ok = 1;
    mid();
    chk1("t2_d_addr_ok", d_addr_ok, 1'b1);
    chk1("t2_i_addr_ok0", i_addr_ok, 1'b0);
    chk32("t2_m_addr", m_addr, 32'h80001000);
    chk1("t2_m_write", m_write, 1'b1);
    next();
    d_valid = 0; m_data_ok = 1;
    mid();
    chk1("t2_d_data_ok", d_data_ok, 1'b1);
    chk1("t2_i_addr_ok1", i_addr_ok, 1'b0);
    next();
    m_data_ok = 0;
    mid();
    chk1("t2_i_grant", i_addr_ok, 1'b1);
    chk32("t2_i_m_addr", m_addr, 32'hbfc00004);
    next();
    i_valid = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h24080001;
    mid();
    chk1("t2_i_data_ok", i_data_ok, 1'b1);
    next();
    idle_in();
    next();

    // Flush while the fetch is outstanding.
    i_valid = 1; i_addr = 32'hbfc00010; m_addr_ok = 1;
    mid();
    chk1("t3_i_addr_ok", i_addr_ok, 1'b1);
    next();
    i_valid = 0; m_addr_ok = 0; i_flush = 1;
    mid();
    next();
    i_flush = 0; m_data_ok = 1; m_rdata = 32'hdeadbeef;
    mid();
    chk1("t3_stale_dropped", i_data_ok, 1'b0);
    next();
    m_data_ok = 0;
    i_valid = 1; i_addr = 32'hbfc00100; m_addr_ok = 1;
    mid();
    chk1("t3_new_addr_ok", i_addr_ok, 1'b1);
    chk32("t3_new_m_addr", m_addr, 32'hbfc00100);
    next();
    i_valid = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h11112222;
    mid();
    chk1("t3_new_data_ok", i_data_ok, 1'b1);
    chk32("t3_new_rdata", i_rdata, 32'h11112222);
    next();
    idle_in();
    next();

    // Memory stalls the load address phase.
    d_valid = 1; d_write = 0; d_size = 2;
    d_addr = 32'h80002000;
    i_valid = 1; i_addr = 32'hbfc00200;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk1("t4_m_valid", m_valid, 1'b1);
      chk32("t4_m_addr", m_addr, 32'h80002000);
      chk1("t4_no_i_grant", i_addr_ok, 1'b0);
      next();
    end
    m_addr_ok = 1;
    mid();
    chk1("t4_d_addr_ok", d_addr_ok, 1'b1);
    next();
    d_valid = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h55aa00ff;
    mid();
    chk1("t4_d_data_ok", d_data_ok, 1'b1);
    chk32("t4_d_rdata", d_rdata, 32'h55aa00ff);
    next();
    m_data_ok = 0; m_addr_ok = 1;
    mid();
    chk1("t4_i_grant", i_addr_ok, 1'b1);
    next();
    i_valid = 0; m_addr_ok = 0; m_data_ok = 1;
    mid();
    chk1("t4_i_data_ok", i_data_ok, 1'b1);
    next();
    idle_in();

    // Both ports saturate a zero-wait memory.
    reset = 1;
    next();
    reset = 0;
    i_valid = 1; i_addr = 32'hbfc00300;
    d_valid = 1; d_size = 2; d_addr = 32'h80003000;
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0badcafe;
    grants.delete();
    for (int k = 0; k < 20; k++) begin
      mid();
      if (d_addr_ok) grants.push_back("D");
      if (i_addr_ok) grants.push_back("I");
      next();
    end
    idle_in();
    exp_order = FAIR ? "DDDDIDDDDI" : "DDDDDDDDDD";
    chk32("t5_grant_count", 32'(grants.size()), 32'd10);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      chk32("t5_grant_order", 32'(grants[k]),
            32'(exp_order[k]));
    next();

    // Reset while a load waits for its response.
    d_valid = 1; d_size = 2; d_addr = 32'h80004000;
    m_addr_ok = 1;
    mid();
    chk1("t6_d_addr_ok", d_addr_ok, 1'b1);
    next();
    idle_in();
    reset = 1;
    next();
    reset = 0;
    mid();
    chk1("t6_m_valid", m_valid, 1'b0);
    chk32("t6_m_addr", m_addr, 32'h0);
    chk1("t6_d_data_ok", d_data_ok, 1'b0);
    chk1("t6_d_addr_ok", d_addr_ok, 1'b0);
    next();
    i_valid = 1; i_addr = 32'hbfc00000; m_addr_ok = 1;
    mid();
    chk1("t6_i_addr_ok", i_addr_ok, 1'b1);
    next();
    i_valid = 0; m_addr_ok = 0;
    m_data_ok = 1; m_rdata = 32'h3c1d0001;
    mid();
    chk1("t6_i_data_ok", i_data_ok, 1'b1);
    chk32("t6_i_rdata", i_rdata, 32'h3c1d0001);
    next();
    idle_in();
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one split-handshake memory port between the instruction-fetch port and the data (load/store) port of the CPU core. It grants one transaction at a time: data has priority over fetch, and an optional starvation guard limits how long fetch can be locked out. It tracks the single outstanding transaction and steers the response back to its owner. Fetch responses made stale by a pipeline flush are absorbed here, so the fetch unit only ever sees data for its current address stream.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits (1..15); used only with the fairness macro.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- i_valid  in  1  fetch request
- i_addr  in  32  fetch address
- i_flush  in  1  fetch redirect (flush/eret/exception)
- i_addr_ok  out  1  fetch request accepted
- i_data_ok  out  1  fetch data valid
- i_rdata  out  32  fetch data
- d_valid  in  1  data request
- d_write  in  1  1 = store
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_addr  in  32  data address
- d_strobe  in  4  byte write enables
- d_wdata  in  32  store data
- d_addr_ok  out  1  data request accepted
- d_data_ok  out  1  data response (load data or store done)
- d_rdata  out  32  load data
- m_valid, m_write, m_size, m_addr, m_strobe, m_wdata  out  1/1/2/32/4/32  memory request
- m_addr_ok  in  1  memory accepted request
- m_data_ok  in  1  memory response
- m_rdata  in  32  memory read data

## Operation
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA. Only one transaction is outstanding at a time.
- IDLE: the winner is chosen combinationally and its request is forwarded on m_* in the same cycle.
  - Fetch requests drive m_write=0, m_size=2, m_strobe=0.
  - If m_addr_ok is seen, pulse the winner's addr_ok and go to X_DATA. Otherwise go to X_ADDR with the grant locked.
  - With no requests: m_valid=0 and all m_* fields are 0.
- Arbitration: d_valid beats i_valid. The starvation guard can override this (see Configuration).
- X_ADDR: keep forwarding the locked requester's current fields. On m_addr_ok, pulse its addr_ok and go to X_DATA. The requester must hold valid until addr_ok; a fetch address change is forwarded as-is.
- X_DATA: m_valid=0. On m_data_ok, forward it to the owner as x_data_ok with x_rdata=m_rdata, then return to IDLE.
- Kill flag:
  - Set when i_flush=1 in I_DATA, or when i_flush=1 in the same cycle as a fetch i_addr_ok.
  - While set, the fetch m_data_ok is consumed and i_data_ok stays 0.
  - Cleared on that m_data_ok.
  - i_flush in any other state has no effect.
- m_data_ok in IDLE or X_ADDR is ignored.
- i_rdata and d_rdata are a direct pass-through of m_rdata; only the ok strobes are gated.

## Timing
- Reset values: state=IDLE, kill=0, starvation counter=0, m_valid=0, all m_* fields 0, all addr_ok/data_ok outputs 0.
- addr_ok is combinational from m_addr_ok: 0-cycle added latency.
- data_ok and rdata are combinational from m_data_ok and m_rdata.
- After a data_ok there is one IDLE cycle before the next grant.
- Minimum transaction: issue in cycle N, response in cycle N+1, next issue in cycle N+2.
- reset mid-transaction: return to IDLE immediately. The memory side shares the same reset, so no stale response is expected.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A counter (4 bits) increments when data wins in IDLE while i_valid=1, saturating at STARVE_LIMIT.
  - It clears when fetch is granted.
  - When the counter equals STARVE_LIMIT and both ports are valid, fetch wins.
- Undefined: strict data priority, and no counter register exists.

## Test plan
- Fetch only, i_addr=0xbfc00000, memory accepts at once and responds one cycle later with 0x3c1d0001 -> i_addr_ok in cycle 0, i_data_ok with i_rdata=0x3c1d0001 in cycle 1, m_write=0, m_size=2.
- d_valid and i_valid rise together, store d_addr=0x80001000, d_strobe=0xf -> data is granted first and fetch is granted in the IDLE cycle after d_data_ok.
- Fetch accepted, i_flush pulses in I_DATA, then m_data_ok arrives -> i_data_ok stays 0, and the next fetch (new address) is issued normally.
- m_addr_ok withheld for 3 cycles while in D_ADDR with d_addr=0x80002000 -> m_valid=1 and m_addr=0x80002000 held stable for 3 cycles, and no fetch grant in that window.
- With ARB_FAIRNESS_EN and STARVE_LIMIT=4, d_valid and i_valid held at 1 -> grant order D,D,D,D,I, repeating. Without the macro -> all grants go to data.
- reset asserted in D_DATA -> the next cycle is in IDLE with all outputs 0, and a subsequent fetch completes normally.
